// File: rtl/eth_csum_pkg.sv
// eth_csum_pkg: shared types and helpers for the Ethernet checksum engine
//   state_t  - frame-state FSM encoding
//   lanes_of - 16-bit lane count for a stream width (LANES = DATA_W/16)
//   cnt_w_of - byte counter width for a maximum frame size
//   fold     - 32->16 bit ones'-complement end-around-carry fold
package eth_csum_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, FOLD} state_t;

    function automatic int lanes_of(input int data_w);
        return data_w / 16;
    endfunction

    function automatic int cnt_w_of(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

    function automatic logic [15:0] fold(input logic [31:0] a);
        logic [16:0] s;
        s = {1'b0, a[31:16]} + {1'b0, a[15:0]};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/eth_csum_lane_adder.sv
// eth_csum_lane_adder: stage 1, masks lanes outside the summed region and sums frame-aligned words
//   i_clk, i_reset_n   clock, async active-low reset
//   i_valid            beat valid; registers update only on valid beats
//   i_data, i_keep     stream lanes, lane 0 first on the wire
//   i_offset           frame byte index of lane 0
//   o_sum              registered sum of DATA_W/16 words
//   o_nbytes           registered count of bytes that contributed
module eth_csum_lane_adder
    import eth_csum_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int START_BYTE = 34,
    parameter int CNT_W = 14,
    localparam int LANES = lanes_of(DATA_W),
    localparam int BYTES = DATA_W / 8,
    localparam int SUM_W = 16 + $clog2(LANES),
    localparam int NB_W = $clog2(BYTES + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic [BYTES-1:0]  i_keep,
    input  logic [CNT_W-1:0]  i_offset,
    output logic [SUM_W-1:0]  o_sum,
    output logic [NB_W-1:0]   o_nbytes
);

    logic [BYTES-1:0] en;
    logic [7:0]       b [BYTES];
    logic [SUM_W-1:0] sum_c;
    logic [NB_W-1:0]  nb_c;

    // Beats before the last are always full, so i_offset is even and lane 2j
    // is always the MSB of a frame-aligned word.
    always_comb begin
        sum_c = '0;
        nb_c = '0;
        for (int k = 0; k < BYTES; k++) begin
            en[k] = i_keep[k] && (int'(i_offset) + k >= START_BYTE);
            b[k] = en[k] ? i_data[8*k +: 8] : 8'h00;
            nb_c = nb_c + NB_W'(en[k]);
        end
        for (int j = 0; j < LANES; j++)
            sum_c = sum_c + SUM_W'({b[2*j], b[2*j+1]});
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_sum <= '0;
            o_nbytes <= '0;
        end else if (i_valid) begin
            o_sum <= sum_c;
            o_nbytes <= nb_c;
        end
    end

endmodule

// File: rtl/eth_csum_stream_engine.sv
// eth_csum_stream_engine: ones'-complement checksum of a frame region (START_BYTE..tlast) plus a seed
//   i_clk, i_reset_n     clock, async active-low reset
//   i_rx_axis_*          RX stream tap (tvalid, tdata, tkeep, tlast); no backpressure
//   i_seed               initial sum, sampled on each frame's first beat
//   o_csum, o_byte_count result and summed byte count, valid with o_csum_valid
//   i_csum_ready         result consumer handshake
//   o_overrun            one-cycle pulse when an unconsumed result is overwritten
//   o_csum_ok            only with ETH_CSUM_VERIFY_EN: registered (o_csum == 0)
// Latency: tlast sampled at edge T, result loads at edge T+3.
module eth_csum_stream_engine
    import eth_csum_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int START_BYTE = 34,
    parameter int MAX_FRAME_BYTES = 9018,
    localparam int CNT_W = cnt_w_of(MAX_FRAME_BYTES)
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_rx_axis_tvalid,
    input  logic [DATA_W-1:0]   i_rx_axis_tdata,
    input  logic [DATA_W/8-1:0] i_rx_axis_tkeep,
    input  logic                i_rx_axis_tlast,
    input  logic [15:0]         i_seed,
    output logic [15:0]         o_csum,
    output logic                o_csum_valid,
    input  logic                i_csum_ready,
    output logic [CNT_W-1:0]    o_byte_count,
    output logic                o_overrun
`ifdef ETH_CSUM_VERIFY_EN
    ,
    output logic                o_csum_ok
`endif
);

    localparam int LANES = lanes_of(DATA_W);
    localparam int SUM_W = 16 + $clog2(LANES);
    localparam int NB_W = $clog2(DATA_W / 8 + 1);
    localparam bit ODD = (START_BYTE % 2) == 1;

    logic [CNT_W-1:0] offset, acc_cnt, f_cnt;
    logic             s1_vld, s1_last, s1_first, acc_last, f_vld;
    logic [15:0]      s1_seed, seed_x, folded, res;
    logic [SUM_W-1:0] s1_sum;
    logic [NB_W-1:0]  s1_nb;
    logic [31:0]      acc, f_acc;
    state_t           state;

    eth_csum_lane_adder #(
        .DATA_W    (DATA_W),
        .START_BYTE(START_BYTE),
        .CNT_W     (CNT_W)
    ) u_lane_adder (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_valid  (i_rx_axis_tvalid),
        .i_data   (i_rx_axis_tdata),
        .i_keep   (i_rx_axis_tkeep),
        .i_offset (offset),
        .o_sum    (s1_sum),
        .o_nbytes (s1_nb)
    );

    // With an odd START_BYTE the data is summed on frame alignment and the folded
    // total is byte-swapped; pre-swapping the seed makes that final swap hand the
    // seed back unchanged, so it still adds in as a region-aligned partial sum.
    always_comb begin
        seed_x = ODD ? {s1_seed[7:0], s1_seed[15:8]} : s1_seed;
        folded = fold(f_acc);
        res = ~(ODD ? {folded[7:0], folded[15:8]} : folded);
    end

    // Frame tracking and stage-1 side-band, aligned with the lane adder registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            offset <= '0;
            s1_vld <= 1'b0;
            s1_last <= 1'b0;
            s1_first <= 1'b0;
            s1_seed <= '0;
        end else begin
            s1_vld <= i_rx_axis_tvalid;
            if (i_rx_axis_tvalid) begin
                offset <= i_rx_axis_tlast ? '0 : offset + CNT_W'(DATA_W / 8);
                s1_last <= i_rx_axis_tlast;
                s1_first <= offset == '0;
                if (offset == '0)
                    s1_seed <= i_seed;
            end
        end
    end

    // Stage 2 accumulator and stage 3 fold input
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc <= '0;
            acc_cnt <= '0;
            acc_last <= 1'b0;
            f_vld <= 1'b0;
            f_acc <= '0;
            f_cnt <= '0;
        end else begin
            if (s1_vld) begin
                acc <= s1_first ? 32'(seed_x) + 32'(s1_sum) : acc + 32'(s1_sum);
                acc_cnt <= (s1_first ? '0 : acc_cnt) + CNT_W'(s1_nb);
            end
            acc_last <= s1_vld && s1_last;
            f_vld <= acc_last;
            if (acc_last) begin
                f_acc <= acc;
                f_cnt <= acc_cnt;
            end
        end
    end

    // Frame-state tracking; the datapath is pipelined independently of it
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= IDLE;
        else
            case (state)
                IDLE:    if (i_rx_axis_tvalid) state <= ACCUM;
                ACCUM:   if (acc_last) state <= FOLD;
                FOLD:    state <= (s1_vld || i_rx_axis_tvalid) ? ACCUM : IDLE;
                default: state <= IDLE;
            endcase
    end

    // Result register with valid/ready hand-off
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_csum <= '0;
            o_byte_count <= '0;
            o_csum_valid <= 1'b0;
            o_overrun <= 1'b0;
`ifdef ETH_CSUM_VERIFY_EN
            o_csum_ok <= 1'b0;
`endif
        end else begin
            o_overrun <= f_vld && o_csum_valid && !i_csum_ready;
            if (f_vld) begin
                o_csum <= res;
                o_byte_count <= f_cnt;
                o_csum_valid <= 1'b1;
`ifdef ETH_CSUM_VERIFY_EN
                o_csum_ok <= res == 16'h0000;
`endif
            end else if (i_csum_ready)
                o_csum_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eth_csum_stream_engine.sv
// tb_eth_csum_stream_engine: directed and randomized frames on a 64-bit/even-start and a 128-bit/odd-start engine
module tb_eth_csum_stream_engine;

    typedef byte unsigned bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_tvalid = 1'b0, a_tlast = 1'b0, a_ready = 1'b1;
    logic [63:0]  a_tdata = '0;
    logic [7:0]   a_tkeep = '0;
    logic [15:0]  a_seed = '0;
    logic [15:0]  a_csum;
    logic [13:0]  a_cnt;
    logic         a_vld, a_ovr;
    logic         b_tvalid = 1'b0, b_tlast = 1'b0, b_ready = 1'b1;
    logic [127:0] b_tdata = '0;
    logic [15:0]  b_tkeep = '0;
    logic [15:0]  b_seed = '0;
    logic [15:0]  b_csum;
    logic [13:0]  b_cnt;
    logic         b_vld, b_ovr;
`ifdef ETH_CSUM_VERIFY_EN
    logic         a_ok, b_ok;
`endif

    eth_csum_stream_engine u_a (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_rx_axis_tvalid(a_tvalid), .i_rx_axis_tdata(a_tdata), .i_rx_axis_tkeep(a_tkeep),
        .i_rx_axis_tlast(a_tlast), .i_seed(a_seed),
        .o_csum(a_csum), .o_csum_valid(a_vld), .i_csum_ready(a_ready),
        .o_byte_count(a_cnt), .o_overrun(a_ovr)
`ifdef ETH_CSUM_VERIFY_EN
        , .o_csum_ok(a_ok)
`endif
    );

    eth_csum_stream_engine #(.DATA_W(128), .START_BYTE(35)) u_b (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_rx_axis_tvalid(b_tvalid), .i_rx_axis_tdata(b_tdata), .i_rx_axis_tkeep(b_tkeep),
        .i_rx_axis_tlast(b_tlast), .i_seed(b_seed),
        .o_csum(b_csum), .o_csum_valid(b_vld), .i_csum_ready(b_ready),
        .o_byte_count(b_cnt), .o_overrun(b_ovr)
`ifdef ETH_CSUM_VERIFY_EN
        , .o_csum_ok(b_ok)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;
    int ovr_a = 0;
    logic [31:0] qa[$], qb[$];
    logic [31:0] ea, eb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Textbook Internet checksum over the region bytes, paired from the region start.
    // Returns {byte_count, checksum}.
    function automatic logic [31:0] model(input bq_t f, input int sb, input logic [15:0] seed);
        int unsigned s;
        int n;
        s = seed;
        n = 0;
        for (int i = sb; i < f.size(); i += 2) begin
            s += {f[i], (i + 1 < f.size()) ? f[i+1] : 8'h00};
            n += (i + 1 < f.size()) ? 2 : 1;
        end
        while (s > 32'hFFFF)
            s = (s & 32'hFFFF) + (s >> 16);
        return {16'(n), ~s[15:0]};
    endfunction

    function automatic bq_t zeros(input int n);
        bq_t q;
        repeat (n) q.push_back(8'h00);
        return q;
    endfunction

    task automatic idle();
        @(negedge clk);
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
    endtask

    // Drives a frame; leaves the last beat on the bus so frames can run back to back.
    // Non-first beats carry a random seed to show it is only sampled on the first beat.
    task automatic send(input int sel, input bq_t f, input logic [15:0] seed, input int gap,
                        input int cut = 1 << 20);
        logic [127:0] d;
        logic [15:0]  k;
        logic [15:0]  sd;
        int w;
        w = sel ? 16 : 8;
        for (int p = 0; p < f.size() && p < cut; p += w) begin
            while ($urandom_range(99) < gap) idle();
            d = '0;
            k = '0;
            for (int i = 0; i < w; i++)
                if (p + i < f.size()) begin
                    d[8*i +: 8] = f[p+i];
                    k[i] = 1'b1;
                end
            sd = (p == 0) ? seed : 16'($urandom);
            @(negedge clk);
            if (sel == 0) begin
                a_tvalid = 1'b1; a_tdata = d[63:0]; a_tkeep = k[7:0];
                a_tlast = (p + w >= f.size()); a_seed = sd;
            end else begin
                b_tvalid = 1'b1; b_tdata = d; b_tkeep = k;
                b_tlast = (p + w >= f.size()); b_seed = sd;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (a_ovr) ovr_a++;
        if (rst_n && a_vld && a_ready) begin
            if (qa.size() == 0)
                chk("a_unexpected_result", qa.size(), 1);
            else begin
                ea = qa.pop_front();
                chk("a_csum", a_csum, ea[15:0]);
                chk("a_cnt", a_cnt, ea[31:16]);
`ifdef ETH_CSUM_VERIFY_EN
                chk("a_ok", a_ok, ea[15:0] == 16'h0000);
`endif
            end
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (rst_n && b_vld && b_ready) begin
            if (qb.size() == 0)
                chk("b_unexpected_result", qb.size(), 1);
            else begin
                eb = qb.pop_front();
                chk("b_csum", b_csum, eb[15:0]);
                chk("b_cnt", b_cnt, eb[31:16]);
`ifdef ETH_CSUM_VERIFY_EN
                chk("b_ok", b_ok, eb[15:0] == 16'h0000);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f, g;
        logic [15:0] seed;
        logic [31:0] r;
        int base;
        repeat (3) @(negedge clk);
        chk("rst_a_csum", a_csum, 0);
        chk("rst_a_vld", a_vld, 0);
        chk("rst_a_cnt", a_cnt, 0);
        chk("rst_b_vld", b_vld, 0);
        chk("rst_b_ovr", b_ovr, 0);
        rst_n = 1'b1;

        // All-zero frame and T+3 latency
        qa.push_back({16'd8, 16'hFFFF});
        send(0, zeros(42), 16'h0000, 0);
        idle();
        chk("lat_T", a_vld, 0);
        repeat (2) begin
            @(negedge clk);
            chk("lat_early", a_vld, 0);
        end
        @(negedge clk);
        chk("lat_T3", a_vld, 1);
        drain();

        f = zeros(42); f[34] = 8'h12; f[35] = 8'h34;
        qa.push_back({16'd8, 16'hEDCB});
        send(0, f, 16'h0000, 30);
        idle();
        f = zeros(42); f[34] = 8'hFF; f[35] = 8'hFF; f[37] = 8'h01;
        qa.push_back({16'd8, 16'hFFFE});
        send(0, f, 16'h0000, 0);
        idle();
        f = zeros(37); f[35] = 8'hAB;
        qb.push_back({16'd2, 16'h54FF});
        send(1, f, 16'h0000, 0);
        idle();
        drain();

        // Back-to-back: result loads on consecutive edges, accepted while reloading
        base = ovr_a;
        f = zeros(42); f[40] = 8'h55; f[41] = 8'h0F;
        qa.push_back(model(f, 34, 16'h0102));
        qa.push_back({16'd0, 16'hEDCB});
        send(0, f, 16'h0102, 0);
        send(0, zeros(8), 16'h1234, 0);
        idle();
        drain();
        chk("simul_no_ovr", ovr_a - base, 0);

        // Same pair with no consumer: the second overwrites the first
        base = ovr_a;
        a_ready = 1'b0;
        send(0, f, 16'h0102, 0);
        send(0, zeros(8), 16'hF00F, 0);
        idle();
        repeat (6) @(negedge clk);
        chk("ovr_once", ovr_a - base, 1);
        chk("ovr_hold_vld", a_vld, 1);
        chk("ovr_hold_csum", a_csum, 16'h0FF0);
        chk("ovr_hold_cnt", a_cnt, 0);
        qa.push_back({16'd0, 16'h0FF0});
        a_ready = 1'b1;
        drain();

        // Reset with a result pending and a partial frame in flight
        a_ready = 1'b0;
        f = zeros(50); f[36] = 8'h77;
        send(0, f, 16'h0000, 0);
        idle();
        repeat (5) @(negedge clk);
        g = zeros(60);
        foreach (g[i]) g[i] = 8'($urandom);
        send(0, g, 16'hABCD, 0, 40);
        @(negedge clk);
        rst_n = 1'b0;
        a_tvalid = 1'b0;
        #1;
        chk("rst_mid_vld", a_vld, 0);
        chk("rst_mid_csum", a_csum, 0);
        chk("rst_mid_cnt", a_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_ready = 1'b1;
        f = zeros(64);
        foreach (f[i]) f[i] = 8'($urandom);
        qa.push_back(model(f, 34, 16'h2468));
        send(0, f, 16'h2468, 10);
        idle();
        drain();

        // Randomized frames, gaps and back-to-back runs on both engines
        for (int s = 0; s < 2; s++)
            for (int n = 0; n < 40; n++) begin
                f = {};
                repeat ($urandom_range(120, 1)) f.push_back(8'($urandom));
                seed = 16'($urandom);
                r = model(f, s ? 35 : 34, seed);
                if (s == 1) qb.push_back(r);
                else qa.push_back(r);
                send(s, f, seed, 20);
                if ($urandom_range(1) == 1) idle();
            end
        idle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
